// File: rtl/sort_pkg.sv
// Shared constants and elaboration helpers for the pipelined N-way sorter.
// Latency: none (package only).
// Backpressure: n/a.
package sort_pkg;

    localparam int SORT_N = 10;
    localparam int SORT_W = 32;

    // Number of register slices needed when one slice follows every spr layers.
    function automatic int slice_count(input int n, input int spr);
        return (n + spr - 1) / spr;
    endfunction

    // Lower median lane index for n lanes.
    function automatic int median_idx(input int n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/sort_cas.sv
// Single compare-and-swap cell; equal keys pass straight through so ties stay stable.
// Latency: combinational.
// Backpressure: n/a (no state).
module sort_cas #(
    parameter int W      = 32,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic a_gt_b;
    logic b_gt_a;
    logic swap;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_gt_b = $signed(a) > $signed(b);
            assign b_gt_a = $signed(b) > $signed(a);
        end else begin : g_unsigned
            assign a_gt_b = a > b;
            assign b_gt_a = b > a;
        end
    endgenerate

    assign swap = desc ? b_gt_a : a_gt_b;
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_pipe_nway.sv
// N-lane odd-even transposition sorter, ascending/descending per beat, with tag and median tap.
// Latency: ceil(N/SPR) cycles, one register slice after every SPR compare layers.
// Backpressure: global stall; every slice holds while out_valid && !out_ready, in_ready = !out_valid || out_ready.
module sort_pipe_nway
    import sort_pkg::*;
#(
    parameter int N      = SORT_N,
    parameter int W      = SORT_W,
    parameter int SPR    = 2,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_desc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [N*W-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_desc,
    output logic [TAG_W-1:0] out_tag,
    output logic [N*W-1:0]   out_data,
    output logic [W-1:0]     out_median
);

    localparam int S   = slice_count(N, SPR);
    localparam int MED = median_idx(N);

    typedef logic [N-1:0][W-1:0] lanes_t;

    logic en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    genvar k, i, s;
    generate
        for (k = 0; k < N; k++) begin : g_layer
            lanes_t din;
            lanes_t dout;
            logic   desc;

            // A layer reads either the input port, the slice register in front of it, or the previous layer.
            if (k == 0) begin : g_src_in
                assign din  = in_data;
                assign desc = in_desc;
            end else if (k % SPR == 0) begin : g_src_reg
                assign din  = g_slice[k/SPR-1].dat;
                assign desc = g_slice[k/SPR-1].desc;
            end else begin : g_src_comb
                assign din  = g_layer[k-1].dout;
                assign desc = g_layer[k-1].desc;
            end

            for (i = 0; i < N; i++) begin : g_lane
                if ((i % 2 == k % 2) && (i + 1 < N)) begin : g_pair
                    sort_cas #(
                        .W      (W),
                        .SIGNED (SIGNED)
                    ) u_cas (
                        .a    (din[i]),
                        .b    (din[i+1]),
                        .desc (desc),
                        .lo   (dout[i]),
                        .hi   (dout[i+1])
                    );
                end else if ((i == 0) || ((i - 1) % 2 != k % 2)) begin : g_pass
                    assign dout[i] = din[i];
                end
            end
        end

        for (s = 0; s < S; s++) begin : g_slice
            localparam int LAST = (((s + 1) * SPR < N) ? (s + 1) * SPR : N) - 1;

            lanes_t           dat;
            logic             desc;
            logic             vld;
            logic [TAG_W-1:0] tag;
            logic             nxt_vld;
            logic [TAG_W-1:0] nxt_tag;

            if (s == 0) begin : g_head
                assign nxt_vld = in_valid & en;
                assign nxt_tag = in_tag;
            end else begin : g_body
                assign nxt_vld = g_slice[s-1].vld;
                assign nxt_tag = g_slice[s-1].tag;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat  <= '0;
                    desc <= 1'b0;
                    vld  <= 1'b0;
                    tag  <= '0;
                end else if (en) begin
                    dat  <= g_layer[LAST].dout;
                    desc <= g_layer[LAST].desc;
                    vld  <= nxt_vld;
                    tag  <= nxt_tag;
                end
            end
        end
    endgenerate

    assign out_valid  = g_slice[S-1].vld;
    assign out_desc   = g_slice[S-1].desc;
    assign out_tag    = g_slice[S-1].tag;
    assign out_data   = g_slice[S-1].dat;
    assign out_median = g_slice[S-1].dat[MED];

endmodule

// File: tb/tb_sort_pipe_nway.sv
// Bench for sort_pipe_nway: four configurations, scoreboard of expected beats, stall and reset checks.
module tb_sort_pipe_nway;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_desc;
    logic [7:0]   in_tag;
    logic [319:0] in_data;
    logic         out_ready;
    int           sel;

    // Main (N=10, SPR=2), signed, 3-lane (SPR=3), and one-layer-per-slice instances.
    logic a_ov, a_ir, a_odesc; logic [7:0] a_ot; logic [319:0] a_od; logic [31:0] a_om;
    logic s_ov, s_ir, s_odesc; logic [7:0] s_ot; logic [319:0] s_od; logic [31:0] s_om;
    logic t_ov, t_ir, t_odesc; logic [7:0] t_ot; logic [95:0]  t_od; logic [31:0] t_om;
    logic u_ov, u_ir, u_odesc; logic [7:0] u_ot; logic [319:0] u_od; logic [31:0] u_om;

    logic         o_vld, o_rdy, o_desc;
    logic [7:0]   o_tag;
    logic [319:0] o_dat;
    logic [31:0]  o_med;

    typedef struct {
        logic [319:0] dat;
        logic [31:0]  med;
        logic [7:0]   tag;
        logic         desc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    sort_pipe_nway #(.N(10), .W(32), .SPR(2), .SIGNED(0), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(a_ir),
        .in_desc(in_desc), .in_tag(in_tag), .in_data(in_data),
        .out_valid(a_ov), .out_ready(out_ready), .out_desc(a_odesc), .out_tag(a_ot),
        .out_data(a_od), .out_median(a_om));

    sort_pipe_nway #(.N(10), .W(32), .SPR(2), .SIGNED(1), .TAG_W(8)) dut_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(s_ir),
        .in_desc(in_desc), .in_tag(in_tag), .in_data(in_data),
        .out_valid(s_ov), .out_ready(out_ready), .out_desc(s_odesc), .out_tag(s_ot),
        .out_data(s_od), .out_median(s_om));

    sort_pipe_nway #(.N(3), .W(32), .SPR(3), .SIGNED(0), .TAG_W(8)) dut_n3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(t_ir),
        .in_desc(in_desc), .in_tag(in_tag), .in_data(in_data[95:0]),
        .out_valid(t_ov), .out_ready(out_ready), .out_desc(t_odesc), .out_tag(t_ot),
        .out_data(t_od), .out_median(t_om));

    sort_pipe_nway #(.N(10), .W(32), .SPR(1), .SIGNED(0), .TAG_W(8)) dut_spr1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 3), .in_ready(u_ir),
        .in_desc(in_desc), .in_tag(in_tag), .in_data(in_data),
        .out_valid(u_ov), .out_ready(out_ready), .out_desc(u_odesc), .out_tag(u_ot),
        .out_data(u_od), .out_median(u_om));

    always_comb begin
        o_vld = a_ov; o_rdy = a_ir; o_desc = a_odesc; o_tag = a_ot; o_dat = a_od; o_med = a_om;
        case (sel)
            1: begin o_vld = s_ov; o_rdy = s_ir; o_desc = s_odesc; o_tag = s_ot; o_dat = s_od; o_med = s_om; end
            2: begin o_vld = t_ov; o_rdy = t_ir; o_desc = t_odesc; o_tag = t_ot; o_dat = {224'b0, t_od}; o_med = t_om; end
            3: begin o_vld = u_ov; o_rdy = u_ir; o_desc = u_odesc; o_tag = u_ot; o_dat = u_od; o_med = u_om; end
            default: ;
        endcase
    end

    // Reference: plain insertion sort on the selected key ordering.
    function automatic logic [319:0] ref_sort(input logic [319:0] d, input int n, input bit sgn, input bit ds);
        logic [31:0]  k [32];
        logic [31:0]  t;
        logic [319:0] r;
        bit           lt;
        for (int i = 0; i < n; i++) k[i] = d[i*32 +: 32];
        for (int i = 1; i < n; i++)
            for (int j = i; j > 0; j--) begin
                lt = sgn ? ($signed(k[j]) < $signed(k[j-1])) : (k[j] < k[j-1]);
                if (lt) begin t = k[j]; k[j] = k[j-1]; k[j-1] = t; end
            end
        r = '0;
        for (int i = 0; i < n; i++) r[i*32 +: 32] = ds ? k[n-1-i] : k[i];
        return r;
    endfunction

    // One clock: drive after the falling edge, report what the next rising edge will accept/deliver.
    task automatic step(input logic v, input logic [319:0] d, input logic ds, input logic [7:0] t,
                        input logic ordy, output logic acc, output logic dlv);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_desc   = ds;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = v && o_rdy;
        dlv = o_vld && ordy;
        cyc++;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            n_cmp++;
            if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
                n_err++;
                $display("FAIL reset_hs[%0d]: out_valid=%b in_ready=%b, want 0/1", s, o_vld, o_rdy);
            end
            n_cmp++;
            if (o_dat !== '0 || o_med !== '0 || o_tag !== '0 || o_desc !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out[%0d]: data=%h med=%h tag=%h desc=%b, want all 0", s, o_dat, o_med, o_tag, o_desc);
            end
        end
    endtask

    task automatic test_sort_single(input string name, input int s, input logic [319:0] d, input logic ds,
                                    input logic [7:0] t, input logic [319:0] exp_dat,
                                    input logic [31:0] exp_med, input int exp_lat);
        logic acc, dlv;
        int   t0;
        bit   got;
        sel = s;
        step(1'b1, d, ds, t, 1'b1, acc, dlv);
        t0 = cyc;
        n_cmp++;
        if (acc !== 1'b1) begin n_err++; $display("FAIL %s_accept: accepted=%b, want 1", name, acc); end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step(1'b0, '0, 1'b0, 8'h00, 1'b1, acc, dlv);
            if (dlv) begin
                got = 1;
                n_cmp++;
                if (cyc - t0 !== exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d, want %0d", name, cyc - t0, exp_lat); end
                n_cmp++;
                if (o_dat !== exp_dat) begin n_err++; $display("FAIL %s_data: got %h, want %h", name, o_dat, exp_dat); end
                n_cmp++;
                if (o_med !== exp_med) begin n_err++; $display("FAIL %s_median: got %h, want %h", name, o_med, exp_med); end
                n_cmp++;
                if (o_tag !== t || o_desc !== ds) begin
                    n_err++;
                    $display("FAIL %s_side: tag=%h desc=%b, want %h/%b", name, o_tag, o_desc, t, ds);
                end
            end
        end
        if (!got) begin n_cmp++; n_err++; $display("FAIL %s_timeout: no output within 40 cycles", name); end
    endtask

    task automatic test_perm3();
        int           p [6][3] = '{'{10,20,30}, '{10,30,20}, '{20,10,30}, '{20,30,10}, '{30,10,20}, '{30,20,10}};
        logic [319:0] d;
        logic         acc, dlv, ds;
        exp_t         e, g;
        int           sent, rcv;
        sel  = 2;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 100 && rcv < 12; c++) begin
            ds = (sent >= 6);
            d  = '0;
            if (sent < 12)
                for (int j = 0; j < 3; j++) d[j*32 +: 32] = p[sent % 6][j];
            step(sent < 12, d, ds, 8'(sent), 1'b1, acc, dlv);
            if (dlv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL perm3_extra: unexpected beat tag=%h", o_tag);
                end else begin
                    g = sb.pop_front();
                    if (o_dat !== g.dat || o_med !== g.med || o_tag !== g.tag || o_desc !== g.desc) begin
                        n_err++;
                        $display("FAIL perm3_beat: got %h med=%h tag=%h, want %h med=%h tag=%h", o_dat, o_med, o_tag, g.dat, g.med, g.tag);
                    end
                end
                rcv++;
            end
            if (acc) begin
                e.dat = '0;
                e.dat[0 +: 32]  = ds ? 32'd30 : 32'd10;
                e.dat[32 +: 32] = 32'd20;
                e.dat[64 +: 32] = ds ? 32'd10 : 32'd30;
                e.med = 32'd20;
                e.tag = 8'(sent);
                e.desc = ds;
                sb.push_back(e);
                sent++;
            end
        end
        n_cmp++;
        if (rcv !== 12 || sb.size() !== 0) begin
            n_err++; $display("FAIL perm3_count: received %0d, pending %0d, want 12/0", rcv, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        bit           pat [5] = '{1, 1, 0, 0, 0};
        logic [319:0] d, prev_dat;
        logic [7:0]   prev_tag;
        logic         prev_desc, stall_prev, acc, dlv, ds, ordy;
        exp_t         e, g;
        int           sent, rcv;
        sel        = 0;
        sent       = 0;
        rcv        = 0;
        stall_prev = 0;
        prev_dat   = '0;
        prev_tag   = '0;
        prev_desc  = 0;
        for (int c = 0; c < 600 && rcv < 20; c++) begin
            ordy = pat[c % 5];
            ds   = 1'($urandom_range(0, 1));
            for (int j = 0; j < 10; j++)
                d[j*32 +: 32] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) : $urandom;
            step(sent < 20, d, ds, 8'(sent), ordy, acc, dlv);
            if (stall_prev) begin
                n_cmp++;
                if (o_dat !== prev_dat || o_tag !== prev_tag || o_desc !== prev_desc || o_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_hold: output changed during stall, tag %h->%h", prev_tag, o_tag);
                end
            end
            if (o_vld && !ordy) begin
                n_cmp++;
                if (o_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_in_ready: got %b during stall, want 0", o_rdy); end
            end
            if (dlv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra: unexpected beat tag=%h", o_tag);
                end else begin
                    g = sb.pop_front();
                    if (o_dat !== g.dat || o_med !== g.med || o_tag !== g.tag || o_desc !== g.desc) begin
                        n_err++;
                        $display("FAIL b2b_beat: got tag=%h data=%h, want tag=%h data=%h", o_tag, o_dat, g.tag, g.dat);
                    end
                end
                rcv++;
            end
            if (acc) begin
                e.dat  = ref_sort(d, 10, 1'b0, ds);
                e.med  = e.dat[4*32 +: 32];
                e.tag  = 8'(sent);
                e.desc = ds;
                sb.push_back(e);
                sent++;
            end
            stall_prev = o_vld && !ordy;
            prev_dat   = o_dat;
            prev_tag   = o_tag;
            prev_desc  = o_desc;
        end
        n_cmp++;
        if (rcv !== 20 || sb.size() !== 0) begin
            n_err++; $display("FAIL b2b_count: received %0d, pending %0d, want 20/0", rcv, sb.size());
        end
    endtask

    task automatic test_reset_flush();
        logic [319:0] d;
        logic         acc, dlv;
        int           seen;
        sel = 0;
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < 10; j++) d[j*32 +: 32] = 32'(100 * (b + 1) + j);
            step(1'b1, d, 1'b1, 8'hA0 + 8'(b), 1'b1, acc, dlv);
            n_cmp++;
            if (acc !== 1'b1) begin n_err++; $display("FAIL flush_accept[%0d]: accepted=%b, want 1", b, acc); end
        end
        for (int c = 0; c < 4; c++) step(1'b0, '0, 1'b0, 8'h00, 1'b0, acc, dlv);
        n_cmp++;
        if (o_vld !== 1'b1 || o_tag !== 8'hA0) begin
            n_err++; $display("FAIL flush_stalled: out_valid=%b tag=%h, want 1/a0", o_vld, o_tag);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
            n_err++; $display("FAIL flush_async: out_valid=%b in_ready=%b, want 0/1", o_vld, o_rdy);
        end
        n_cmp++;
        if (o_dat !== '0 || o_med !== '0 || o_tag !== '0 || o_desc !== 1'b0) begin
            n_err++; $display("FAIL flush_zero: data=%h tag=%h desc=%b, want 0", o_dat, o_tag, o_desc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, '0, 1'b0, 8'h00, 1'b1, acc, dlv);
            if (o_vld) seen++;
            if (c == 0) begin
                n_cmp++;
                if (o_rdy !== 1'b1) begin n_err++; $display("FAIL flush_ready: in_ready=%b, want 1", o_rdy); end
            end
        end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL flush_ghost: %0d flushed beats appeared, want 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [319:0] d_rev, e_inc, e_dec, d_sgn, e_sgn, d3, e3;
        int           sv [10] = '{-3, 7, 0, -3, 2, 2, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0};
        int           se [10] = '{32'h8000_0000, -3, -3, 0, 0, 1, 2, 2, 7, 32'h7FFF_FFFF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_desc   = 1'b0;
        in_tag    = '0;
        in_data   = '0;
        out_ready = 1'b1;
        sel       = 0;
        for (int i = 0; i < 10; i++) begin
            d_rev[i*32 +: 32] = 32'(9 - i);
            e_inc[i*32 +: 32] = 32'(i);
            e_dec[i*32 +: 32] = 32'(9 - i);
            d_sgn[i*32 +: 32] = sv[i];
            e_sgn[i*32 +: 32] = se[i];
        end
        d3 = '0; d3[0 +: 32] = 32'd30; d3[32 +: 32] = 32'd10; d3[64 +: 32] = 32'd20;
        e3 = '0; e3[0 +: 32] = 32'd10; e3[32 +: 32] = 32'd20; e3[64 +: 32] = 32'd30;

        #3;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;

        test_sort_single("asc",    0, d_rev, 1'b0, 8'h11, e_inc, 32'd4, 5);
        test_sort_single("desc",   0, d_rev, 1'b1, 8'h12, e_dec, 32'd5, 5);
        test_sort_single("signed", 1, d_sgn, 1'b0, 8'h13, e_sgn, 32'd0, 5);
        test_sort_single("n3",     2, d3,    1'b0, 8'h14, e3,    32'd20, 1);
        test_sort_single("spr1",   3, d_rev, 1'b0, 8'h15, e_inc, 32'd4, 10);
        test_perm3();
        test_back_to_back();
        test_reset_flush();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
